// File: rtl/pc_irq_sequencer_if.sv
// pc_irq_sequencer bus bundle
// decoder/flags in, pc + interrupt status out
interface pc_irq_sequencer_if #(
  parameter int AW   = 15,
  parameter int SD   = 16,
  parameter int NIRQ = 4
);
  localparam int SPW = $clog2(SD) + 1;

  logic            step;
  logic [3:0]      mop;
  logic [AW-1:0]   target;
  logic            eq;
  logic            gt;
  logic            lt;
  logic            hlt;
  logic [NIRQ-1:0] irq;
  logic            clr_err;

  logic [AW-1:0]   pc;
  logic            in_isr;
  logic            ie;
  logic [NIRQ-1:0] irq_ack;
  logic [NIRQ-1:0] pending;
  logic [SPW-1:0]  sp;
  logic            stack_ovf;
  logic            stack_udf;

  modport master (
    output step, mop, target, eq, gt, lt,
    output hlt, irq, clr_err,
    input  pc, in_isr, ie, irq_ack,
    input  pending, sp, stack_ovf, stack_udf
  );

  modport slave (
    input  step, mop, target, eq, gt, lt,
    input  hlt, irq, clr_err,
    output pc, in_isr, ie, irq_ack,
    output pending, sp, stack_ovf, stack_udf
  );
endinterface

// File: rtl/pc_irq_sequencer.sv
// Program-counter sequencer with return stack
// and edge-latched prioritised interrupts.
module pc_irq_sequencer #(
  parameter int AW       = 15,
  parameter int SD       = 16,
  parameter int NIRQ     = 4,
  parameter int VEC_BASE = 2
) (
  input logic               clk,
  input logic               rst,
  pc_irq_sequencer_if.slave bus
);
  localparam int SPW = $clog2(SD) + 1;
  localparam int AI  = SPW - 1;
  localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  localparam logic [3:0] OP_JEQ  = 4'd1;
  localparam logic [3:0] OP_JGT  = 4'd2;
  localparam logic [3:0] OP_JLT  = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_NEX  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;
  localparam logic [3:0] OP_EI   = 4'd9;
  localparam logic [3:0] OP_DI   = 4'd10;
  localparam logic [3:0] OP_RETI = 4'd11;

  logic [AW-1:0]   stk [SD];
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] ack_oh;
  logic [IW-1:0]   win;
  logic            take;
  logic            full;
  logic            empty;
  logic [AW-1:0]   pc_inc;
  logic [AW-1:0]   top;
  logic [AW-1:0]   pc_n;
  logic [AW-1:0]   push_val;
  logic [SPW-1:0]  sp_n;
  logic            push;
  logic            pop;
  logic            ie_n;
  logic            isr_n;
  logic            ovf_ev;
  logic            udf_ev;

  assign rise   = bus.irq & ~irq_q;
  assign full   = (bus.sp == SPW'(SD));
  assign empty  = (bus.sp == '0);
  assign pc_inc = bus.pc + 1'b1;
  assign top    = stk[AI'(bus.sp - 1'b1)];
  assign take   = bus.step && (|bus.pending) &&
                  bus.ie && !bus.in_isr && !full;

  // lowest pending index wins
  always_comb begin
    win = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (bus.pending[i]) win = IW'(i);
    end
    ack_oh = NIRQ'(1) << win;
  end

  // next pc / stack / mode decode
  always_comb begin
    pc_n     = bus.pc;
    sp_n     = bus.sp;
    ie_n     = bus.ie;
    isr_n    = bus.in_isr;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = bus.pc;
    ovf_ev   = 1'b0;
    udf_ev   = 1'b0;
    if (take) begin
      push  = 1'b1;
      pc_n  = AW'(VEC_BASE) + AW'(win);
      isr_n = 1'b1;
    end else if (bus.step) begin
      case (bus.mop)
        OP_JEQ: pc_n = bus.eq ? bus.target : pc_inc;
        OP_JGT: pc_n = bus.gt ? bus.target : pc_inc;
        OP_JLT: pc_n = bus.lt ? bus.target : pc_inc;
        OP_JMP: pc_n = bus.target;
        OP_NEX: pc_n = bus.hlt ? bus.pc : pc_inc;
        OP_CALL: begin
          if (full) begin
            ovf_ev = 1'b1;
            pc_n   = pc_inc;
          end else begin
            push     = 1'b1;
            push_val = pc_inc;
            pc_n     = bus.target;
          end
        end
        OP_RET, OP_RETI: begin
          if (empty) begin
            udf_ev = 1'b1;
            pc_n   = pc_inc;
          end else begin
            pop  = 1'b1;
            pc_n = top;
          end
          if (bus.mop == OP_RETI) isr_n = 1'b0;
        end
        OP_EI: begin
          ie_n = 1'b1;
          pc_n = pc_inc;
        end
        OP_DI: begin
          ie_n = 1'b0;
          pc_n = pc_inc;
        end
        default: pc_n = bus.pc;
      endcase
    end
    if (push) sp_n = bus.sp + 1'b1;
    if (pop)  sp_n = bus.sp - 1'b1;
  end

  // architectural state and interrupt latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc        <= '0;
      bus.sp        <= '0;
      bus.ie        <= 1'b1;
      bus.in_isr    <= 1'b0;
      bus.pending   <= '0;
      bus.irq_ack   <= '0;
      bus.stack_ovf <= 1'b0;
      bus.stack_udf <= 1'b0;
      irq_q         <= '0;
    end else begin
      bus.pc        <= pc_n;
      bus.sp        <= sp_n;
      bus.ie        <= ie_n;
      bus.in_isr    <= isr_n;
      irq_q         <= bus.irq;
      bus.pending   <= (bus.pending &
                        ~({NIRQ{take}} & ack_oh)) | rise;
      bus.irq_ack   <= {NIRQ{take}} & ack_oh;
      bus.stack_ovf <= ovf_ev |
                       (bus.stack_ovf & ~bus.clr_err);
      bus.stack_udf <= udf_ev |
                       (bus.stack_udf & ~bus.clr_err);
    end
  end

  // return-stack storage, contents unreset
  always_ff @(posedge clk) begin
    if (push) stk[AI'(bus.sp)] <= push_val;
  end
endmodule

// File: tb/tb_pc_irq_sequencer.sv
// pc_irq_sequencer bench: directed plan
// plus random ops vs queue-based model.
module tb_pc_irq_sequencer;
  localparam int AW   = 15;
  localparam int SD   = 16;
  localparam int NIRQ = 4;
  localparam int VB   = 2;
  localparam int SPW  = $clog2(SD) + 1;
  localparam int VW   = AW + SPW + 4 + 2 * NIRQ;

  localparam logic [3:0] NOP  = 4'd0;
  localparam logic [3:0] JEQ  = 4'd1;
  localparam logic [3:0] JGT  = 4'd2;
  localparam logic [3:0] JMP  = 4'd5;
  localparam logic [3:0] NEX  = 4'd6;
  localparam logic [3:0] CALL = 4'd7;
  localparam logic [3:0] RET  = 4'd8;
  localparam logic [3:0] EI   = 4'd9;
  localparam logic [3:0] DI   = 4'd10;
  localparam logic [3:0] RETI = 4'd11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  pc_irq_sequencer_if #(
    .AW(AW), .SD(SD), .NIRQ(NIRQ)
  ) bus ();

  pc_irq_sequencer #(
    .AW(AW), .SD(SD), .NIRQ(NIRQ), .VEC_BASE(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int              m_pc;
  int              m_stk[$];
  bit              m_ie;
  bit              m_isr;
  bit              m_ovf;
  bit              m_udf;
  logic [NIRQ-1:0] m_pend;
  logic [NIRQ-1:0] m_ack;
  logic [NIRQ-1:0] m_prev;

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ie = 1; m_isr = 0;
    m_ovf = 0; m_udf = 0;
    m_pend = '0; m_ack = '0; m_prev = '0;
  endtask

  task automatic model_clk();
    logic [NIRQ-1:0] rise;
    bit tk, oe, ue;
    int nxt, tg;
    rise = bus.irq & ~m_prev;
    oe = 0; ue = 0;
    nxt = (m_pc + 1) % (1 << AW);
    tg = int'(bus.target);
    tk = bus.step && m_pend != 0 && m_ie &&
         !m_isr && m_stk.size() < SD;
    m_ack = '0;
    if (tk) begin
      for (int i = 0; i < NIRQ; i++) begin
        if (m_pend[i] && m_ack == 0) begin
          m_stk.push_back(m_pc);
          m_pc = (VB + i) % (1 << AW);
          m_ack[i] = 1'b1;
          m_pend[i] = 1'b0;
        end
      end
      m_isr = 1;
    end else if (bus.step) begin
      case (bus.mop)
        4'd1: m_pc = bus.eq ? tg : nxt;
        4'd2: m_pc = bus.gt ? tg : nxt;
        4'd3: m_pc = bus.lt ? tg : nxt;
        4'd5: m_pc = tg;
        4'd6: m_pc = bus.hlt ? m_pc : nxt;
        4'd7: begin
          if (m_stk.size() == SD) begin
            oe = 1; m_pc = nxt;
          end else begin
            m_stk.push_back(nxt); m_pc = tg;
          end
        end
        4'd8, 4'd11: begin
          if (m_stk.size() == 0) begin
            ue = 1; m_pc = nxt;
          end else begin
            m_pc = m_stk.pop_back();
          end
          if (bus.mop == 4'd11) m_isr = 0;
        end
        4'd9:  begin m_ie = 1; m_pc = nxt; end
        4'd10: begin m_ie = 0; m_pc = nxt; end
        default: ;
      endcase
    end
    m_pend = m_pend | rise;
    m_prev = bus.irq;
    m_ovf = oe ? 1'b1 : (bus.clr_err ? 1'b0 : m_ovf);
    m_udf = ue ? 1'b1 : (bus.clr_err ? 1'b0 : m_udf);
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.pc, bus.sp, bus.in_isr, bus.ie,
            bus.pending, bus.irq_ack,
            bus.stack_ovf, bus.stack_udf};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {AW'(m_pc), SPW'(m_stk.size()),
            m_isr, m_ie, m_pend, m_ack, m_ovf, m_udf};
  endfunction

  task automatic idle_in();
    bus.step = 0; bus.mop = NOP; bus.target = '0;
    bus.eq = 0; bus.gt = 0; bus.lt = 0;
    bus.hlt = 0; bus.clr_err = 0;
  endtask

  task automatic cyc();
    model_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] m,
                     input logic [AW-1:0] t);
    bus.step = 1; bus.mop = m; bus.target = t;
    cyc();
    bus.step = 0; bus.mop = NOP;
  endtask

  task automatic apply_reset();
    idle_in();
    bus.irq = '0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    if (dut_vec() !== mdl_vec()) begin
      nerr++;
      $display("FAIL reset_vec got %h want %h",
               dut_vec(), mdl_vec());
    end
    ncmp++;
    if (bus.pc !== '0 || bus.ie !== 1'b1) begin
      nerr++;
      $display("FAIL reset_pc_ie pc=%h ie=%b want 0/1",
               bus.pc, bus.ie);
    end
    ncmp++;
  endtask

  task automatic test_nex();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      run(NEX, '0);
      if (bus.pc !== AW'(i)) begin
        nerr++;
        $display("FAIL nex pc=%h want %h", bus.pc, i);
      end
      ncmp++;
    end
    bus.hlt = 1;
    run(NEX, '0);
    bus.hlt = 0;
    if (bus.pc !== 15'd3) begin
      nerr++;
      $display("FAIL nex_hlt pc=%h want 3", bus.pc);
    end
    ncmp++;
  endtask

  task automatic test_branch();
    apply_reset();
    run(JMP, 15'd10);
    bus.eq = 1;
    run(JEQ, 15'h40);
    bus.eq = 0;
    if (bus.pc !== 15'h40) begin
      nerr++;
      $display("FAIL jeq pc=%h want 40", bus.pc);
    end
    ncmp++;
    bus.gt = 0;
    run(JGT, 15'h99);
    if (bus.pc !== 15'h41) begin
      nerr++;
      $display("FAIL jgt pc=%h want 41", bus.pc);
    end
    ncmp++;
    run(JMP, 15'h7fff);
    run(NEX, '0);
    if (bus.pc !== 15'h0) begin
      nerr++;
      $display("FAIL wrap pc=%h want 0", bus.pc);
    end
    ncmp++;
  endtask

  task automatic test_call_ret();
    apply_reset();
    run(JMP, 15'd5);
    run(CALL, 15'h100);
    if (bus.pc !== 15'h100 || bus.sp !== 5'd1) begin
      nerr++;
      $display("FAIL call pc=%h sp=%0d want 100/1",
               bus.pc, bus.sp);
    end
    ncmp++;
    run(RET, '0);
    if (bus.pc !== 15'd6 || bus.sp !== 5'd0) begin
      nerr++;
      $display("FAIL ret pc=%h sp=%0d want 6/0",
               bus.pc, bus.sp);
    end
    ncmp++;
    run(RET, '0);
    if (bus.pc !== 15'd7 || bus.stack_udf !== 1'b1 ||
        bus.sp !== 5'd0) begin
      nerr++;
      $display("FAIL udf pc=%h udf=%b sp=%0d want 7/1/0",
               bus.pc, bus.stack_udf, bus.sp);
    end
    ncmp++;
    bus.clr_err = 1;
    cyc();
    bus.clr_err = 0;
    if (bus.stack_udf !== 1'b0) begin
      nerr++;
      $display("FAIL clr_udf got %b want 0", bus.stack_udf);
    end
    ncmp++;
  endtask

  task automatic test_overflow();
    logic [AW-1:0] p;
    apply_reset();
    for (int i = 0; i < SD; i++) run(CALL, AW'(16'h200 + i));
    if (bus.sp !== 5'd16) begin
      nerr++;
      $display("FAIL fill sp=%0d want 16", bus.sp);
    end
    ncmp++;
    p = bus.pc;
    run(CALL, 15'h300);
    if (bus.stack_ovf !== 1'b1 || bus.sp !== 5'd16 ||
        bus.pc !== p + 1'b1) begin
      nerr++;
      $display("FAIL ovf ovf=%b sp=%0d pc=%h want 1/16/%h",
               bus.stack_ovf, bus.sp, bus.pc, p + 1'b1);
    end
    ncmp++;
    bus.irq = 4'b0001;
    run(NOP, '0);
    run(NOP, '0);
    if (bus.pending !== 4'b0001 || bus.in_isr !== 1'b0 ||
        bus.pc !== p + 1'b1) begin
      nerr++;
      $display("FAIL full_irq pend=%b isr=%b pc=%h",
               bus.pending, bus.in_isr, bus.pc);
    end
    ncmp++;
    if (dut_vec() !== mdl_vec()) begin
      nerr++;
      $display("FAIL ovf_vec got %h want %h",
               dut_vec(), mdl_vec());
    end
    ncmp++;
  endtask

  task automatic test_priority();
    apply_reset();
    run(JMP, 15'h20);
    bus.irq = 4'b0110;
    cyc();
    run(JMP, 15'h55);
    if (bus.pc !== 15'd3 || bus.irq_ack !== 4'b0010 ||
        bus.in_isr !== 1'b1 || bus.pending !== 4'b0100) begin
      nerr++;
      $display("FAIL take1 pc=%h ack=%b isr=%b pend=%b",
               bus.pc, bus.irq_ack, bus.in_isr, bus.pending);
    end
    ncmp++;
    cyc();
    if (bus.irq_ack !== 4'b0000) begin
      nerr++;
      $display("FAIL ack_pulse ack=%b want 0000", bus.irq_ack);
    end
    ncmp++;
    run(RETI, '0);
    if (bus.pc !== 15'h20 || bus.in_isr !== 1'b0) begin
      nerr++;
      $display("FAIL reti pc=%h isr=%b want 20/0",
               bus.pc, bus.in_isr);
    end
    ncmp++;
    run(NOP, '0);
    if (bus.pc !== 15'd4 || bus.irq_ack !== 4'b0100) begin
      nerr++;
      $display("FAIL take2 pc=%h ack=%b want 4/0100",
               bus.pc, bus.irq_ack);
    end
    ncmp++;
    bus.irq = '0;
  endtask

  task automatic test_di_ei_rst();
    apply_reset();
    run(DI, '0);
    bus.irq = 4'b0001;
    run(NEX, '0);
    run(NEX, '0);
    if (bus.pending[0] !== 1'b1 || bus.in_isr !== 1'b0 ||
        bus.pc !== 15'd3) begin
      nerr++;
      $display("FAIL di_hold pend=%b isr=%b pc=%h",
               bus.pending, bus.in_isr, bus.pc);
    end
    ncmp++;
    run(EI, '0);
    run(NEX, '0);
    if (bus.pc !== 15'd2 || bus.in_isr !== 1'b1) begin
      nerr++;
      $display("FAIL ei_take pc=%h isr=%b want 2/1",
               bus.pc, bus.in_isr);
    end
    ncmp++;
    #2;
    rst = 1;
    #1;
    if (bus.pc !== '0 || bus.in_isr !== 1'b0 ||
        bus.pending !== '0 || bus.ie !== 1'b1) begin
      nerr++;
      $display("FAIL async_rst pc=%h isr=%b pend=%b ie=%b",
               bus.pc, bus.in_isr, bus.pending, bus.ie);
    end
    ncmp++;
    apply_reset();
  endtask

  task automatic test_random();
    logic [3:0] ops [16] = '{4'd0, 4'd1, 4'd2, 4'd3,
                             4'd5, 4'd6, 4'd7, 4'd7,
                             4'd8, 4'd8, 4'd9, 4'd10,
                             4'd11, 4'd11, 4'd4, 4'd12};
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.step    = ($urandom_range(0, 3) != 0);
      bus.mop     = ops[$urandom_range(0, 15)];
      bus.target  = AW'($urandom);
      bus.eq      = 1'($urandom);
      bus.gt      = 1'($urandom);
      bus.lt      = 1'($urandom);
      bus.hlt     = ($urandom_range(0, 3) == 0);
      bus.clr_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.irq = bus.irq ^ NIRQ'($urandom);
      cyc();
      if (dut_vec() !== mdl_vec()) begin
        nerr++;
        $display("FAIL rand[%0d] got %h want %h",
                 n, dut_vec(), mdl_vec());
      end
      ncmp++;
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    bus.irq = '0;
    model_reset();
    test_reset();
    test_nex();
    test_branch();
    test_call_ret();
    test_overflow();
    test_priority();
    test_di_ei_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
